// File: rtl/rebble_spi_rx.sv
// ----------------------------------------------------------------------------
// rebble_spi_rx
//
// SPI slave front end of the Rebble display path. The MCU streams command
// bytes over cs/sck/mosi (SPI mode 0, MSB first). This block decodes them
// into 6-bit pixel writes on the frame-buffer write port. The LCD scan-out
// engine reads that buffer. SPI is oversampled in the master clock domain,
// so f_sck must be at most f_clock/8.
//
// Ports
//   clock           in   master clock, rising edge
//   reset           in   asynchronous, active-low reset
//   cs              in   SPI chip select, active-low, asynchronous
//   sck             in   SPI clock, asynchronous
//   mosi            in   SPI data in
//   miso            out  status byte during the command byte, 0 otherwise
//   pixel_in        out  frame-buffer write data {r[1:0],g[1:0],b[1:0]}
//   pixel_waddr     out  frame-buffer write address
//   pixel_write_en  out  one-cycle write strobe
//   frame_ready     out  one-cycle pulse with the write of the last pixel
//   overflow        out  sticky: a write was attempted outside the buffer
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | cs high, or cs low without a seen falling edge (after reset)
//   CMD      | receiving the command byte, status byte goes out on miso
//   ADDR_HI  | CMD_WRITE_AT: receiving the high address byte
//   ADDR_LO  | CMD_WRITE_AT: receiving the low address byte
//   DATA     | each byte is one pixel write, address auto-increments
//   DISCARD  | bytes ignored until cs rises (after frame end: they overflow)
// ----------------------------------------------------------------------------
module rebble_spi_rx #(
    parameter int         FB_PIXELS       = 24192,
    parameter int         ADDRW           = 15,
    parameter int         DATAW           = 6,
    parameter logic [7:0] CMD_WRITE_FRAME = 8'h01,
    parameter logic [7:0] CMD_WRITE_AT    = 8'h02
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cs,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic [DATAW-1:0] pixel_in,
    output logic [ADDRW-1:0] pixel_waddr,
    output logic             pixel_write_en,
    output logic             frame_ready,
    output logic             overflow
);

    localparam int               HIW       = ADDRW - 8;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR_HI = 3'd2,
        ADDR_LO = 3'd3,
        DATA    = 3'd4,
        DISCARD = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic cs_s1, cs_s2, cs_d;
    logic sck_s1, sck_s2, sck_d;
    logic mosi_s1, mosi_s2;

    // The cs chain resets to "selected" so that a cs already low when reset
    // releases produces no falling edge: the rest of that cs-low period is
    // left in IDLE and ignored until cs rises and falls again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_d    <= 1'b0;
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_fall  =  cs_d  & ~cs_s2;
    assign cs_rise  = ~cs_d  &  cs_s2;
    assign sck_rise =  sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 &  sck_d;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [2:0]       bit_cnt;
    logic [6:0]       rx_shift;
    logic [6:0]       tx_shift;
    logic [7:0]       rx_byte;
    logic             active;
    logic             byte_done;
    logic [HIW-1:0]   addr_hi;
    logic [ADDRW-1:0] addr;
    logic [ADDRW-1:0] addr_rx;
    logic             addr_oob;
    logic             at_end;
    logic             frame_flag;
    logic             ovf_flag;
    logic [7:0]       status;

    assign active    = (state != IDLE) & ~cs_s2;
    assign rx_byte   = {rx_shift, mosi_s2};
    assign byte_done = active & sck_rise & (bit_cnt == 3'd7);
    assign addr_rx   = {addr_hi, rx_byte};
    assign addr_oob  = 32'(addr_rx) >= 32'(FB_PIXELS);
    assign status    = {1'b1, 5'b0, ovf_flag, frame_flag};

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    logic do_write, do_frame, set_ovf, clr_flags;
    logic addr_clr, hi_ld, addr_ld, end_set;

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        set_ovf   = 1'b0;
        clr_flags = 1'b0;
        addr_clr  = 1'b0;
        hi_ld     = 1'b0;
        addr_ld   = 1'b0;
        end_set   = 1'b0;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else if (cs_fall) begin
            state_nxt = CMD;
        end else if (byte_done) begin
            case (state)
                CMD: begin
                    clr_flags = 1'b1;
                    if (rx_byte == CMD_WRITE_FRAME) begin
                        addr_clr  = 1'b1;
                        state_nxt = DATA;
                    end else if (rx_byte == CMD_WRITE_AT) begin
                        state_nxt = ADDR_HI;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
                ADDR_HI: begin
                    hi_ld     = 1'b1;
                    state_nxt = ADDR_LO;
                end
                ADDR_LO: begin
                    if (addr_oob) begin
                        set_ovf   = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        addr_ld   = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    do_write = 1'b1;
                    if (addr == LAST_ADDR) begin
                        end_set   = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
                DISCARD: begin
                    // Past the last pixel there is no wrap; more pixels overflow.
                    set_ovf = at_end;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign do_frame = do_write & (addr == LAST_ADDR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (cs_fall || cs_rise) begin
            bit_cnt  <= 3'd0;
        end else if (active && sck_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte[6:0];
        end
    end

    // Status goes out MSB first; bit 7 is driven directly at cs fall and the
    // remaining bits shift out on successive sck falls, then zeros.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_shift <= 7'd0;
            miso     <= 1'b0;
        end else if (cs_fall) begin
            tx_shift <= status[6:0];
            miso     <= status[7];
        end else if (cs_rise) begin
            tx_shift <= 7'd0;
            miso     <= 1'b0;
        end else if (active && sck_fall) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
            miso     <= tx_shift[6];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_hi <= '0;
            addr    <= '0;
            at_end  <= 1'b0;
        end else begin
            if (hi_ld) begin
                addr_hi <= rx_byte[HIW-1:0];
            end
            if (addr_clr) begin
                addr <= '0;
            end else if (addr_ld) begin
                addr <= addr_rx;
            end else if (do_write && !do_frame) begin
                addr <= addr + ADDRW'(1);
            end
            if (cs_fall) begin
                at_end <= 1'b0;
            end else if (end_set) begin
                at_end <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_in       <= '0;
            pixel_waddr    <= '0;
            pixel_write_en <= 1'b0;
            frame_ready    <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            pixel_write_en <= do_write;
            frame_ready    <= do_frame;
            if (do_write) begin
                pixel_in    <= rx_byte[DATAW-1:0];
                pixel_waddr <= addr;
            end
            if (set_ovf) begin
                overflow <= 1'b1;
            end
        end
    end

    // Set has priority over the clear issued by a completed command byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (do_frame) begin
                frame_flag <= 1'b1;
            end else if (clr_flags) begin
                frame_flag <= 1'b0;
            end
            if (set_ovf) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rebble_spi_rx.sv
// ----------------------------------------------------------------------------
// tb_rebble_spi_rx
//
// Directed bench for rebble_spi_rx. SPI master runs at clock/8 (four clocks
// per sck phase), driving on the falling edge of clock. A monitor logs every
// pixel write sampled on the falling edge of clock.
// ----------------------------------------------------------------------------
module tb_rebble_spi_rx;

    localparam int HALF = 4;

    logic        clock;
    logic        reset;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic [5:0]  pixel_in;
    logic [14:0] pixel_waddr;
    logic        pixel_write_en;
    logic        frame_ready;
    logic        overflow;

    int total;
    int bad;

    rebble_spi_rx dut (
        .clock          (clock),
        .reset          (reset),
        .cs             (cs),
        .sck            (sck),
        .mosi           (mosi),
        .miso           (miso),
        .pixel_in       (pixel_in),
        .pixel_waddr    (pixel_waddr),
        .pixel_write_en (pixel_write_en),
        .frame_ready    (frame_ready),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // write monitor
    logic [14:0] wq_a[$];
    logic [5:0]  wq_d[$];
    logic        wq_f[$];
    logic        prev_we;
    int          strobe_long;
    int          fr_orphan;

    initial begin
        prev_we     = 1'b0;
        strobe_long = 0;
        fr_orphan   = 0;
    end

    always @(negedge clock) begin
        if (pixel_write_en === 1'b1) begin
            wq_a.push_back(pixel_waddr);
            wq_d.push_back(pixel_in);
            wq_f.push_back(frame_ready);
        end
        if (pixel_write_en === 1'b1 && prev_we === 1'b1) strobe_long <= strobe_long + 1;
        if (frame_ready === 1'b1 && pixel_write_en !== 1'b1) fr_orphan <= fr_orphan + 1;
        prev_we <= pixel_write_en;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_log();
        wq_a.delete();
        wq_d.delete();
        wq_f.delete();
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] mo);
        mo = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_clk(HALF);
            mo = {mo[6:0], miso};
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] mo);
        spi_bits(b, 8, mo);
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        wait_clk(5);
    endtask

    task automatic cs_end();
        wait_clk(4);
        cs = 1'b1;
        wait_clk(6);
    endtask

    task automatic status_txn(output logic [7:0] mo);
        logic [7:0] d;
        cs_begin();
        spi_byte(8'h7E, mo);
        spi_byte(8'h00, d);
        cs_end();
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [14:0] ea, input logic [5:0] ed, input logic ef);
        total++;
        if (wq_a.size() <= idx) begin
            bad++;
            $display("FAIL %s: write %0d missing, got %0d writes", name, idx, wq_a.size());
        end else if (wq_a[idx] !== ea || wq_d[idx] !== ed || wq_f[idx] !== ef) begin
            bad++;
            $display("FAIL %s: write %0d got addr=%0d data=%h fr=%b, want addr=%0d data=%h fr=%b",
                     name, idx, wq_a[idx], wq_d[idx], wq_f[idx], ea, ed, ef);
        end
    endtask

    task automatic check_count(input string name, input int want);
        total++;
        if (wq_a.size() != want) begin
            bad++;
            $display("FAIL %s: write count got %0d want %0d", name, wq_a.size(), want);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_outputs_reset(input string name);
        logic [24:0] got;
        got = {miso, pixel_in, pixel_waddr, pixel_write_en, frame_ready, overflow};
        total++;
        if (got !== 25'd0) begin
            bad++;
            $display("FAIL %s: miso=%b pixel_in=%h waddr=%0d we=%b fr=%b ovf=%b, want all 0",
                     name, miso, pixel_in, pixel_waddr, pixel_write_en, frame_ready, overflow);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cs    = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        wait_clk(3);
        check_outputs_reset("reset_held");
        reset = 1'b1;
        wait_clk(8);
        check_outputs_reset("reset_released");
    endtask

    task automatic test_write_frame();
        logic [7:0] mo;
        logic [7:0] d;
        int         lat;
        clear_log();
        cs_begin();
        spi_byte(8'h01, mo);
        check_byte("frame_status", mo, 8'h80);
        // first pixel bit by bit to measure strobe latency from the 8th sck rise
        spi_bits(8'h3F, 7, d);
        mosi = 1'b1;
        wait_clk(HALF);
        sck = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clock);
            if (pixel_write_en === 1'b1) lat = k;
        end
        wait_clk(1);
        sck = 1'b0;
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL write_latency: strobe seen %0d clocks after sck rise, want 3", lat);
        end
        spi_byte(8'hC5, d);
        spi_byte(8'h00, d);
        cs_end();
        check_count("frame_count", 3);
        check_write("frame_w0", 0, 15'd0, 6'h3F, 1'b0);
        check_write("frame_w1", 1, 15'd1, 6'h05, 1'b0);
        check_write("frame_w2", 2, 15'd2, 6'h00, 1'b0);
    endtask

    task automatic test_write_at_last();
        logic [7:0] mo;
        logic [7:0] d;
        clear_log();
        cs_begin();
        spi_byte(8'h02, d);
        spi_byte(8'h5E, d);
        spi_byte(8'h7F, d);
        spi_byte(8'h2A, d);
        cs_end();
        check_count("last_count", 1);
        check_write("last_w0", 0, 15'd24191, 6'h2A, 1'b1);
        status_txn(mo);
        check_byte("status_after_frame", mo, 8'h81);
        status_txn(mo);
        check_byte("status_cleared", mo, 8'h80);
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] d;
        logic [2:0] st;
        clear_log();
        cs_begin();
        spi_byte(8'h7E, d);
        spi_byte(8'h12, d);
        spi_byte(8'h34, d);
        cs_end();
        check_count("unknown_count", 0);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL unknown_ovf: got %b want 0", overflow);
        end
        st = dut.state;
        total++;
        if (st !== 3'd0) begin
            bad++;
            $display("FAIL unknown_idle: state got %0d want 0", st);
        end
    endtask

    task automatic test_partial_byte();
        logic [7:0] d;
        clear_log();
        cs_begin();
        spi_byte(8'h01, d);
        spi_bits(8'hFF, 4, d);
        cs_end();
        check_count("partial_count", 0);
        cs_begin();
        spi_byte(8'h01, d);
        spi_byte(8'h11, d);
        cs_end();
        check_count("partial_next_count", 1);
        check_write("partial_next_w0", 0, 15'd0, 6'h11, 1'b0);
    endtask

    task automatic test_overflow_addr();
        logic [7:0] mo;
        logic [7:0] d;
        clear_log();
        cs_begin();
        spi_byte(8'h02, d);
        spi_byte(8'h5E, d);
        spi_byte(8'h80, d);
        cs_end();
        check_count("oob_count", 0);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL oob_ovf: got %b want 1", overflow);
        end
        status_txn(mo);
        check_byte("status_after_oob", mo, 8'h82);
        status_txn(mo);
        check_byte("status_oob_cleared", mo, 8'h80);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL oob_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] mo;
        logic [7:0] d;
        int         n_before;
        clear_log();
        cs_begin();
        spi_byte(8'h01, d);
        spi_byte(8'h2A, d);
        spi_byte(8'h15, d);
        spi_bits(8'h55, 4, d);
        #3 reset = 1'b0;
        wait_clk(2);
        check_outputs_reset("midreset_held");
        reset = 1'b1;
        n_before = wq_a.size();
        spi_bits(8'h55, 4, d);
        spi_byte(8'h22, mo);
        check_outputs_reset("midreset_after_bits");
        check_byte("midreset_miso", mo, 8'h00);
        cs_end();
        total++;
        if (wq_a.size() != n_before) begin
            bad++;
            $display("FAIL midreset_nowrite: got %0d writes want %0d", wq_a.size(), n_before);
        end
        clear_log();
        cs_begin();
        spi_byte(8'h01, mo);
        check_byte("midreset_status", mo, 8'h80);
        spi_byte(8'h01, d);
        cs_end();
        check_count("midreset_new_count", 1);
        check_write("midreset_new_w0", 0, 15'd0, 6'h01, 1'b0);
    endtask

    task automatic test_past_end();
        logic [7:0] mo;
        logic [7:0] d;
        clear_log();
        cs_begin();
        spi_byte(8'h02, d);
        spi_byte(8'hDE, d);   // bit 7 of the high byte is ignored
        spi_byte(8'h7F, d);
        spi_byte(8'h2A, d);
        spi_byte(8'h11, d);
        cs_end();
        check_count("past_end_count", 1);
        check_write("past_end_w0", 0, 15'd24191, 6'h2A, 1'b1);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL past_end_ovf: got %b want 1", overflow);
        end
        status_txn(mo);
        check_byte("status_past_end", mo, 8'h83);
    endtask

    task automatic test_strobes();
        total++;
        if (strobe_long != 0) begin
            bad++;
            $display("FAIL strobe_width: %0d multi-cycle strobes, want 0", strobe_long);
        end
        total++;
        if (fr_orphan != 0) begin
            bad++;
            $display("FAIL frame_ready_align: %0d cycles without write_en, want 0", fr_orphan);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_frame();
        test_write_at_last();
        test_unknown_cmd();
        test_partial_byte();
        test_overflow_addr();
        test_reset_mid_data();
        test_past_end();
        test_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
